dac_sample_fifo: RTL and testbench

DAC_SAMPLE_FIFO -- requirements
Module: dac_sample_fifo

---
 rtl/dac_sample_fifo.sv | 119 +++++++++++
 tb/tb_dac_sample_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: sample buffer between an upstream AXI-Stream source and a
// DAC driver that pulls one sample per DAC period. Output is held off (FILL)
// until PRIME_LEVEL samples are stored, then streams (RUN).
// Optional feature macro: DAC_FIFO_HOLD_LAST_EN -- on underflow, keep
// presenting the last popped sample and stay in RUN instead of re-priming.
module dac_sample_fifo #(
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 4
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     s_axis_valid,
    output logic                     s_axis_ready,
    input  logic [15:0]              s_axis_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic [15:0]              m_axis_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              underflow_cnt
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PRIME_L = (AW+1)'(PRIME_LEVEL);

    typedef enum logic {FILL, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [15:0]     last_sample_q, last_sample_d;
    logic [15:0]     underflow_cnt_q, underflow_cnt_d;
    logic [15:0]     mem_q [DEPTH];

    logic full, empty, wr_en, run_en, pop, underflow;

    // Handshake decode from registered pointers; extra MSB separates full from empty.
    always_comb begin
        full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty        = (wr_ptr_q == rd_ptr_q);
        s_axis_ready = !rst && !full;
        wr_en        = s_axis_valid && s_axis_ready;
        run_en       = (state_q == RUN) && en;
        pop          = run_en && m_axis_ready && !empty;
        underflow    = run_en && m_axis_ready && empty;
`ifdef DAC_FIFO_HOLD_LAST_EN
        m_axis_valid = run_en;
        m_axis_data  = empty ? last_sample_q : mem_q[rd_ptr_q[AW-1:0]];
`else
        m_axis_valid = run_en && !empty;
        m_axis_data  = mem_q[rd_ptr_q[AW-1:0]];
`endif
        level         = level_q;
        underflow_cnt = underflow_cnt_q;
    end

    // Next-state for pointers, occupancy, hold register, underflow counter and FSM.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        last_sample_d   = last_sample_q;
        underflow_cnt_d = underflow_cnt_q;
        state_d         = state_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + 1'b1;
            last_sample_d = m_axis_data;
        end

        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (underflow && underflow_cnt_q != 16'hFFFF)
            underflow_cnt_d = underflow_cnt_q + 1'b1;

        case (state_q)
            FILL: if (en && level_q >= PRIME_L) state_d = RUN;
            RUN: begin
                if (!en) state_d = FILL;
`ifndef DAC_FIFO_HOLD_LAST_EN
                else if (underflow) state_d = FILL;
`endif
            end
            default: state_d = FILL;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge mclk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            last_sample_q   <= '0;
            underflow_cnt_q <= '0;
            state_q         <= FILL;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            last_sample_q   <= last_sample_d;
            underflow_cnt_q <= underflow_cnt_d;
            state_q         <= state_d;
        end
    end

    // Sample storage; contents are intentionally not cleared by reset.
    always_ff @(posedge mclk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_axis_data;
    end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed bench for dac_sample_fifo (DEPTH=16, PRIME_LEVEL=4).
module tb_dac_sample_fifo;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        s_axis_valid = 1'b0;
    logic        s_axis_ready;
    logic [15:0] s_axis_data = '0;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b0;
    logic [15:0] m_axis_data;
    logic [4:0]  level;
    logic [15:0] underflow_cnt;

    int total = 0;
    int bad   = 0;

    dac_sample_fifo #(.DEPTH(16), .PRIME_LEVEL(4)) dut (
        .mclk(mclk), .rst(rst), .en(en),
        .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
        .level(level), .underflow_cnt(underflow_cnt)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] d);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        tick();
        s_axis_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] d);
        chk({tag, "_vld"}, 32'(m_axis_valid), 32'd1);
        chk(tag, 32'(m_axis_data), 32'(d));
        m_axis_ready = 1'b1;
        tick();
        m_axis_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_ready", 32'(s_axis_ready), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_mvld", 32'(m_axis_valid), 32'd0);
        chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(s_axis_ready), 32'd1);

        // Priming
        en = 1'b1;
        wr(16'h1000); wr(16'h1001); wr(16'h1002);
        chk("prime3_mvld", 32'(m_axis_valid), 32'd0);
        chk("prime3_level", 32'(level), 32'd3);
        wr(16'h1003);
        chk("prime4_level", 32'(level), 32'd4);
        chk("prime4_mvld", 32'(m_axis_valid), 32'd0);
        tick();
        chk("prime_run_mvld", 32'(m_axis_valid), 32'd1);
        chk("prime_run_data", 32'(m_axis_data), 32'h1000);
        for (int i = 0; i < 4; i++) pop_chk("prime_pop", 16'(16'h1000 + i));
        chk("drained_level", 32'(level), 32'd0);

`ifdef DAC_FIFO_HOLD_LAST_EN
        // Hold-last underflow: stays in RUN presenting the last popped sample
        for (int i = 0; i < 3; i++) begin
            m_axis_ready = 1'b1; tick(); m_axis_ready = 1'b0;
        end
        chk("hold_ucnt", 32'(underflow_cnt), 32'd3);
        chk("hold_mvld", 32'(m_axis_valid), 32'd1);
        chk("hold_data", 32'(m_axis_data), 32'h1003);
        wr(16'h3000);
        chk("hold_run_mvld", 32'(m_axis_valid), 32'd1);
        chk("hold_run_data", 32'(m_axis_data), 32'h3000);
`else
        // Underflow returns to FILL; output held off until re-primed
        m_axis_ready = 1'b1; tick(); m_axis_ready = 1'b0;
        chk("uf_ucnt", 32'(underflow_cnt), 32'd1);
        chk("uf_mvld", 32'(m_axis_valid), 32'd0);
        wr(16'h3000);
        tick();
        chk("uf_fill1_mvld", 32'(m_axis_valid), 32'd0);
        wr(16'h3001); wr(16'h3002);
        tick();
        chk("uf_fill3_mvld", 32'(m_axis_valid), 32'd0);
        wr(16'h3003);
        tick();
        chk("uf_rerun_mvld", 32'(m_axis_valid), 32'd1);
        chk("uf_rerun_data", 32'(m_axis_data), 32'h3000);
`endif

        // Clean slate
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("rst2_ucnt", 32'(underflow_cnt), 32'd0);
        chk("rst2_level", 32'(level), 32'd0);

        // Full and wrap with output disabled
        en = 1'b0;
        for (int i = 0; i < 16; i++) wr(16'(16'h2000 + i));
        chk("full_level", 32'(level), 32'd16);
        chk("full_ready", 32'(s_axis_ready), 32'd0);
        m_axis_ready = 1'b1; tick(); m_axis_ready = 1'b0;
        chk("fill_pull_ucnt", 32'(underflow_cnt), 32'd0);
        chk("fill_pull_level", 32'(level), 32'd16);
        wr(16'h2FFF);
        chk("full_reject_level", 32'(level), 32'd16);
        en = 1'b1;
        tick();
        // Pop while full with a write offered: write must be refused
        chk("full_pop_data", 32'(m_axis_data), 32'h2000);
        s_axis_valid = 1'b1; s_axis_data = 16'h2EEE; m_axis_ready = 1'b1;
        tick();
        s_axis_valid = 1'b0; m_axis_ready = 1'b0;
        chk("full_pop_level", 32'(level), 32'd15);
        pop_chk("wrap_pop", 16'h2001);
        pop_chk("wrap_pop", 16'h2002);
        wr(16'h2010); wr(16'h2011); wr(16'h2012);
        chk("wrap_level", 32'(level), 32'd16);
        for (int i = 3; i < 19; i++) pop_chk("wrap_order", 16'(16'h2000 + i));
        chk("wrap_empty_level", 32'(level), 32'd0);
        en = 1'b0;
        tick();

        // Simultaneous write and pop at level 5
        for (int i = 0; i < 5; i++) wr(16'(16'h5000 + i));
        en = 1'b1;
        tick();
        chk("sim_level", 32'(level), 32'd5);
        chk("sim_data0", 32'(m_axis_data), 32'h5000);
        for (int i = 0; i < 2; i++) begin
            s_axis_valid = 1'b1; s_axis_data = 16'(16'h5005 + i); m_axis_ready = 1'b1;
            tick();
            s_axis_valid = 1'b0; m_axis_ready = 1'b0;
            chk("sim_level_hold", 32'(level), 32'd5);
        end
        for (int i = 2; i < 7; i++) pop_chk("sim_order", 16'(16'h5000 + i));
        en = 1'b0;
        tick();
        chk("sim_ucnt", 32'(underflow_cnt), 32'd0);

        // Reset mid-stream at level 9
        for (int i = 0; i < 9; i++) wr(16'(16'h9000 + i));
        chk("mid_level9", 32'(level), 32'd9);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_ucnt", 32'(underflow_cnt), 32'd0);
        chk("mid_rst_mvld", 32'(m_axis_valid), 32'd0);
        chk("mid_rst_ready", 32'(s_axis_ready), 32'd0);
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) wr(16'(16'hA000 + i));
        tick();
        chk("mid_first_mvld", 32'(m_axis_valid), 32'd1);
        chk("mid_first_data", 32'(m_axis_data), 32'hA000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
